// File: rtl/gumnut_alu_pkg.sv
// Shared types and widths for the ALU result stage: the buffered entry
// format and the default datapath and register-file sizes.
package gumnut_alu_pkg;

    localparam int DATA_W   = 8;
    localparam int RADDR_W  = 3;
    localparam int RF_DEPTH = 1 << RADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               cout;
        logic               vout;
        logic               zero;
        logic [RADDR_W-1:0] rd;
        logic               rd_we;
        logic               flag_en;
    } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry in-order buffer of ALU results. Flush has priority over push/pop;
// every slot is exposed so the top level can search it for forwarding.
module alu_result_fifo
    import gumnut_alu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  alu_result_t             push_entry_i,
    output alu_result_t             head_o,
    output alu_result_t [1:0]       entries_o,
    output logic        [1:0]       valid_o,
    output logic                    rd_ptr_o,
    output logic        [1:0]       count_o
);

    alu_result_t [1:0] entries_q, entries_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic        [1:0] count_q, count_d;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                entries_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d            = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entries_q <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // With one entry only the read slot is live; with two both are.
    always_comb begin
        valid_o = 2'b00;
        case (count_q)
            2'd0:    valid_o = 2'b00;
            2'd1:    valid_o = 2'b01 << rd_ptr_q;
            default: valid_o = 2'b11;
        endcase
    end

    assign head_o    = entries_q[rd_ptr_q];
    assign entries_o = entries_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: zero detect, two-entry skid buffer toward
// writeback, Z/C/V commit at pop, and a forwarding lookup over buffered entries.
module alu_result_stage
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W  = gumnut_alu_pkg::DATA_W,
    parameter int RADDR_W = gumnut_alu_pkg::RADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic               in_cout_i,
    input  logic               in_vout_i,
    input  logic [RADDR_W-1:0] in_rd_i,
    input  logic               in_rd_we_i,
    input  logic               in_flag_en_i,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic               wb_we_o,
    output logic [RADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0]  wb_data_o,
    output logic               z_flag_o,
    output logic               c_flag_o,
    output logic               v_flag_o,
    input  logic [RADDR_W-1:0] fwd_addr_i,
    output logic               fwd_hit_o,
    output logic [DATA_W-1:0]  fwd_data_o
);

    alu_result_t       new_entry;
    alu_result_t       head;
    alu_result_t [1:0] entries;
    logic        [1:0] entry_valid;
    logic              rd_ptr;
    logic        [1:0] count;
    logic              push;
    logic              pop;
    logic              fwd_idx;

    logic [2:0]         flags_q, flags_d;
    logic [RADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0]  last_data_q, last_data_d;

    always_comb begin
        new_entry         = '0;
        new_entry.data    = in_data_i;
        new_entry.cout    = in_cout_i;
        new_entry.vout    = in_vout_i;
        new_entry.zero    = (in_data_i == '0);
        new_entry.rd      = in_rd_i;
        new_entry.rd_we   = in_rd_we_i;
        new_entry.flag_en = in_flag_en_i;
    end

    assign in_ready_o = (count != 2'd2) & ~flush_i;
    assign wb_valid_o = (count != 2'd0);
    assign push       = in_valid_i & in_ready_o;
    assign pop        = wb_valid_o & wb_ready_i & ~flush_i;

    alu_result_fifo u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (new_entry),
        .head_o       (head),
        .entries_o    (entries),
        .valid_o      (entry_valid),
        .rd_ptr_o     (rd_ptr),
        .count_o      (count)
    );

    // Flags only move when a flag-enabled entry leaves the buffer.
    always_comb begin
        flags_d     = flags_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        if (pop && head.flag_en) begin
            flags_d = {head.zero, head.cout, head.vout};
        end
        if (wb_valid_o) begin
            last_addr_d = head.rd;
            last_data_d = head.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q     <= 3'b000;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            flags_q     <= flags_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    assign {z_flag_o, c_flag_o, v_flag_o} = flags_q;
    assign wb_we_o   = wb_valid_o & head.rd_we;
    assign wb_addr_o = wb_valid_o ? head.rd   : last_addr_q;
    assign wb_data_o = wb_valid_o ? head.data : last_data_q;

    // Scan oldest slot first so the younger match overrides it.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fwd_idx = rd_ptr ^ k[0];
            if (entry_valid[fwd_idx] && entries[fwd_idx].rd_we &&
                entries[fwd_idx].rd == fwd_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = entries[fwd_idx].data;
            end
        end
    end

endmodule
